// File: rtl/div_sgn_pkg.sv
// Shared types and helpers for the sequential signed restoring divider.
package div_sgn_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        FIX  = 3'd2,
        DONE = 3'd3,
        LOAD = 3'd4
    } div_state_e;

    // Magnitude of the most-negative dividend needs one bit beyond the operand width.
    localparam int unsigned MagExtraBits = 1;

    function automatic int unsigned mag_width(input int unsigned width_x,
                                              input int unsigned width_y);
        return width_x + width_y + MagExtraBits;
    endfunction

    // Edges from accept (inclusive) to OutValid for a normal division.
    function automatic int unsigned latency(input int unsigned width_x, input bit cs_in);
        return width_x + 2 + (cs_in ? 1 : 0);
    endfunction

endpackage

// File: rtl/div_sgn_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract |Y|, keep or restore.
module div_sgn_step #(
    parameter int unsigned widthY = 8,
    parameter int unsigned speed  = 0
) (
    input  logic [widthY:0]   i_rem,
    input  logic              i_bit,
    input  logic [widthY:0]   i_ymag,
    output logic [widthY:0]   o_rem,
    output logic              o_qbit
);

    localparam int unsigned N = widthY + 2;

    logic [N-1:0] w_a;
    logic [N-1:0] w_b;
    logic [N-1:0] w_diff;

    assign w_a = {i_rem, i_bit};
    assign w_b = {1'b0, i_ymag};

    generate
        if (speed == 0) begin : g_ripple
            always_comb begin
                logic c;
                c      = 1'b1;
                w_diff = '0;
                for (int i = 0; i < int'(N); i++) begin
                    w_diff[i] = w_a[i] ^ ~w_b[i] ^ c;
                    c         = (w_a[i] & ~w_b[i]) | (c & (w_a[i] | ~w_b[i]));
                end
            end
        end else begin : g_prefix
            // Prefix structures are left to synthesis via the operator.
            assign w_diff = w_a - w_b;
        end
    endgenerate

    assign o_qbit = ~w_diff[N-1];
    assign o_rem  = o_qbit ? w_diff[N-2:0] : w_a[N-2:0];

endmodule

// File: rtl/div_sgn_seq.sv
// Iterative signed divider D = Q*Y + R, one quotient bit per clock, valid/ready on both sides.
// Define DIV_SGN_CS_IN_EN to take the dividend in carry-save form (DS + DC) with an extra LOAD cycle.
module div_sgn_seq
    import div_sgn_pkg::*;
#(
    parameter int unsigned widthX = 8,
    parameter int unsigned widthY = 8,
    parameter int unsigned speed  = 0
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic                            InValid,
    output logic                            InReady,
`ifdef DIV_SGN_CS_IN_EN
    input  logic [widthX+widthY-1:0]        DS,
    input  logic [widthX+widthY-1:0]        DC,
`else
    input  logic signed [widthX+widthY-1:0] D,
`endif
    input  logic signed [widthY-1:0]        Y,
    output logic                            OutValid,
    input  logic                            OutReady,
    output logic signed [widthX-1:0]        Q,
    output logic signed [widthY-1:0]        R,
    output logic                            DivZero,
    output logic                            Ovf
);

    localparam int unsigned WD   = widthX + widthY;
    localparam int unsigned MW   = mag_width(widthX, widthY);
    localparam int unsigned CntW = (widthX > 1) ? $clog2(widthX) : 1;

    localparam logic [widthX-1:0] QMaxPos = {1'b0, {(widthX-1){1'b1}}};
    localparam logic [widthX-1:0] QMaxNeg = {1'b1, {(widthX-1){1'b0}}};

    div_state_e          r_state;
    logic [CntW-1:0]     r_cnt;
    logic [widthY:0]     r_rem;
    logic [widthX-1:0]   r_dlo;
    logic [widthY:0]     r_ymag;
    logic                r_sd;
    logic                r_sq;
    logic [widthX-1:0]   r_q;
    logic [widthY-1:0]   r_r;
    logic                r_divzero;
    logic                r_ovf;

    logic [WD-1:0]       w_d;
    logic [MW-1:0]       w_dext;
    logic [MW-1:0]       w_dmag;
    logic [widthY:0]     w_yext;
    logic [widthY:0]     w_ymag;
    logic                w_yzero;
    logic                w_pre_ovf;
    logic [widthY:0]     w_step_rem;
    logic                w_step_qbit;
    logic [widthX-1:0]   w_q_fix;
    logic [widthY-1:0]   w_rmag;
    logic [widthY-1:0]   w_r_fix;
    logic                w_fix_ovf;

`ifdef DIV_SGN_CS_IN_EN
    assign w_d = DS + DC;
`else
    assign w_d = D;
`endif

    // Magnitudes are one bit wider than the operands so the most-negative value does not wrap.
    assign w_dext  = {w_d[WD-1], w_d};
    assign w_dmag  = w_d[WD-1] ? -w_dext : w_dext;
    assign w_yext  = {Y[widthY-1], Y};
    assign w_ymag  = Y[widthY-1] ? -w_yext : w_yext;
    assign w_yzero = (Y == '0);

    // Quotient needs more than widthX bits if the top part already reaches |Y|.
    assign w_pre_ovf = (w_dmag[MW-1:widthX] >= w_ymag);

    div_sgn_step #(
        .widthY (widthY),
        .speed  (speed)
    ) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_dlo[widthX-1]),
        .i_ymag (r_ymag),
        .o_rem  (w_step_rem),
        .o_qbit (w_step_qbit)
    );

    assign w_q_fix   = r_sq ? -r_dlo : r_dlo;
    assign w_rmag    = r_rem[widthY-1:0];
    assign w_r_fix   = r_sd ? -w_rmag : w_rmag;
    assign w_fix_ovf = r_sq ? (r_dlo > QMaxNeg) : (r_dlo > QMaxPos);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_dlo     <= '0;
            r_ymag    <= '0;
            r_sd      <= 1'b0;
            r_sq      <= 1'b0;
            r_q       <= '0;
            r_r       <= '0;
            r_divzero <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (InValid) begin
                        r_sd   <= w_d[WD-1];
                        r_sq   <= w_d[WD-1] ^ Y[widthY-1];
                        r_ymag <= w_ymag;
                        r_rem  <= w_dmag[MW-1:widthX];
                        r_dlo  <= w_dmag[widthX-1:0];
                        r_cnt  <= CntW'(widthX - 1);
                        if (w_yzero) begin
                            r_divzero <= 1'b1;
                            r_state   <= DONE;
                        end else if (w_pre_ovf) begin
                            r_ovf   <= 1'b1;
                            r_state <= DONE;
                        end else begin
`ifdef DIV_SGN_CS_IN_EN
                            r_state <= LOAD;
`else
                            r_state <= CALC;
`endif
                        end
                    end
                end
                LOAD: begin
                    r_state <= CALC;
                end
                CALC: begin
                    // Quotient bits shift in behind the dividend bits being consumed.
                    r_rem <= w_step_rem;
                    r_dlo <= {r_dlo[widthX-2:0], w_step_qbit};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_ovf   <= w_fix_ovf;
                    r_q     <= w_fix_ovf ? '0 : w_q_fix;
                    r_r     <= w_fix_ovf ? '0 : w_r_fix;
                    r_state <= DONE;
                end
                DONE: begin
                    if (OutReady) begin
                        r_q       <= '0;
                        r_r       <= '0;
                        r_divzero <= 1'b0;
                        r_ovf     <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign InReady  = (r_state == IDLE);
    assign OutValid = (r_state == DONE);
    assign Q        = r_q;
    assign R        = r_r;
    assign DivZero  = r_divzero;
    assign Ovf      = r_ovf;

endmodule

// File: tb/tb_div_sgn_seq.sv
// Directed self-checking bench for div_sgn_seq at widthX = widthY = 8.
module tb_div_sgn_seq;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] d;
    logic signed [7:0]  y;
    logic               out_valid;
    logic               out_ready;
    logic signed [7:0]  q;
    logic signed [7:0]  r;
    logic               div_zero;
    logic               ovf;

    int checks = 0;
    int errors = 0;

    div_sgn_seq #(
        .widthX (8),
        .widthY (8),
        .speed  (0)
    ) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .InValid  (in_valid),
        .InReady  (in_ready),
`ifdef DIV_SGN_CS_IN_EN
        .DS       (d),
        .DC       (16'd0),
`else
        .D        (d),
`endif
        .Y        (y),
        .OutValid (out_valid),
        .OutReady (out_ready),
        .Q        (q),
        .R        (r),
        .DivZero  (div_zero),
        .Ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands, count edges from the accepting edge (inclusive) until OutValid.
    task automatic run_op(input int dv, input int yv, output int edges);
        d        = 16'(dv);
        y        = 8'(yv);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        edges    = 1;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        if (!out_valid) edges = -1;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_outvalid got %b want 0", out_valid); end
        checks++; if (q !== 8'sd0) begin errors++; $display("FAIL reset_q got %0d want 0", q); end
        checks++; if (r !== 8'sd0) begin errors++; $display("FAIL reset_r got %0d want 0", r); end
        checks++; if (div_zero !== 1'b0 || ovf !== 1'b0) begin
            errors++; $display("FAIL reset_flags got dz=%b ovf=%b want 0 0", div_zero, ovf);
        end
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_inready got %b want 1", in_ready); end
    endtask

    task automatic test_signs();
        int dv[4] = '{100, -100, 100, -100};
        int yv[4] = '{7, 7, -7, -7};
        int qv[4] = '{14, -14, -14, 14};
        int rv[4] = '{2, -2, 2, -2};
        int edges;
        logic signed [7:0] qe, re;
        for (int i = 0; i < 4; i++) begin
            run_op(dv[i], yv[i], edges);
            qe = 8'(qv[i]);
            re = 8'(rv[i]);
            checks++; if (edges != 10) begin errors++; $display("FAIL sign%0d_latency got %0d want 10", i, edges); end
            checks++; if (q !== qe) begin errors++; $display("FAIL sign%0d_q got %0d want %0d", i, q, qe); end
            checks++; if (r !== re) begin errors++; $display("FAIL sign%0d_r got %0d want %0d", i, r, re); end
            checks++; if (ovf !== 1'b0 || div_zero !== 1'b0) begin
                errors++; $display("FAIL sign%0d_flags got dz=%b ovf=%b want 0 0", i, div_zero, ovf);
            end
            finish_op();
        end
    endtask

    task automatic test_div_zero();
        int edges;
        run_op(123, 0, edges);
        checks++; if (edges != 1) begin errors++; $display("FAIL dz_latency got %0d want 1", edges); end
        checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", div_zero); end
        checks++; if (q !== 8'sd0 || r !== 8'sd0 || ovf !== 1'b0) begin
            errors++; $display("FAIL dz_outputs got q=%0d r=%0d ovf=%b want 0 0 0", q, r, ovf);
        end
        finish_op();
    endtask

    task automatic test_overflow();
        int dv[5] = '{128, -128, 1000, -129, 32767};
        int yv[5] = '{1, 1, 2, 1, 127};
        int qv[5] = '{0, -128, 0, 0, 0};
        logic ov[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int lat[5] = '{10, 10, 1, 10, 1};
        int edges;
        logic signed [7:0] qe;
        for (int i = 0; i < 5; i++) begin
            run_op(dv[i], yv[i], edges);
            qe = 8'(qv[i]);
            checks++; if (edges != lat[i]) begin errors++; $display("FAIL ovf%0d_latency got %0d want %0d", i, edges, lat[i]); end
            checks++; if (ovf !== ov[i]) begin errors++; $display("FAIL ovf%0d_flag got %b want %b", i, ovf, ov[i]); end
            checks++; if (q !== qe || r !== 8'sd0) begin
                errors++; $display("FAIL ovf%0d_qr got q=%0d r=%0d want %0d 0", i, q, r, qe);
            end
            finish_op();
        end
    endtask

    task automatic test_back_pressure();
        int edges;
        run_op(100, 7, edges);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                d        = 16'sd50;
                y        = 8'sd5;
                in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("FAIL hold%0d_handshake got ov=%b ir=%b want 1 0", c, out_valid, in_ready);
            end
            checks++; if (q !== 8'sd14 || r !== 8'sd2 || ovf !== 1'b0 || div_zero !== 1'b0) begin
                errors++; $display("FAIL hold%0d_data got q=%0d r=%0d ovf=%b dz=%b want 14 2 0 0",
                                   c, q, r, ovf, div_zero);
            end
        end
        in_valid = 1'b0;
        finish_op();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || q !== 8'sd0 || r !== 8'sd0) begin
            errors++; $display("FAIL release got ov=%b ir=%b q=%0d r=%0d want 0 1 0 0", out_valid, in_ready, q, r);
        end
        run_op(-50, 5, edges);
        checks++; if (q !== -8'sd10 || r !== 8'sd0 || edges != 10) begin
            errors++; $display("FAIL after_hold got q=%0d r=%0d lat=%0d want -10 0 10", q, r, edges);
        end
        finish_op();
    endtask

    task automatic test_reset_mid();
        int edges;
        d        = 16'sd100;
        y        = 8'sd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midcalc_busy got ir=%b want 0", in_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || q !== 8'sd0 || r !== 8'sd0) begin
            errors++; $display("FAIL midreset got ir=%b ov=%b q=%0d r=%0d want 1 0 0 0", in_ready, out_valid, q, r);
        end
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_noout got %b want 0", out_valid); end
        run_op(50, 5, edges);
        checks++; if (q !== 8'sd10 || r !== 8'sd0 || edges != 10) begin
            errors++; $display("FAIL after_reset got q=%0d r=%0d lat=%0d want 10 0 10", q, r, edges);
        end
        finish_op();
    endtask

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        d         = '0;
        y         = '0;
        test_reset();
        test_signs();
        test_div_zero();
        test_overflow();
        test_back_pressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_sgn_seq.md
Name: div_sgn_seq

Overview:
- Iterative signed divider, the inverse of the signed adder-multiplier P = (XS+XC)*Y.
- Given a (widthX+widthY)-bit dividend D and a widthY-bit divisor Y, produces quotient Q (widthX bits) and remainder R (widthY bits) with D = Q*Y + R.
- Restoring division on magnitudes, one quotient bit per clock, valid/ready handshakes on both sides.
- Used wherever a product from the multiplier datapath must be divided back out.

Parameters:
- widthX, 8, quotient width (<= widthY)
- widthY, 8, divisor and remainder width
- speed, 0, performance parameter passed to the internal adder; 0 = ripple, 1 = Brent-Kung, 2 = Sklansky

Ports:
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous active-low reset
- InValid  in  1  operands valid
- InReady  out  1  block can accept operands
- D  in  widthX+widthY  signed dividend
- Y  in  widthY  signed divisor
- OutValid  out  1  results valid
- OutReady  in  1  consumer accepts results
- Q  out  widthX  signed quotient, truncated toward zero
- R  out  widthY  signed remainder, sign of D, |R| < |Y|
- DivZero  out  1  Y was zero
- Ovf  out  1  quotient not representable in widthX bits

Behaviour:
- Reset (async, RST_N=0): state IDLE; InReady=1 after release. OutValid, Q, R, DivZero and Ovf are all 0. Reset mid-operation aborts the division with no output.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - InReady=1; accept on InValid&InReady.
  - At accept, register |D|, |Y|, sD = D sign and sQ = D sign ^ Y sign.
  - Y==0: go to DONE with DivZero=1, Q=0, R=0.
  - Else if upper widthY bits of |D| >= |Y| (unsigned): go to DONE with Ovf=1, Q=0, R=0.
  - Else: go to CALC and load iteration counter = widthX-1.
- CALC, one step per cycle, MSB first:
  - Trial-subtract |Y| from the partial remainder shifted left with the next dividend bit.
  - Quotient bit = 1 if the result is non-negative, and the partial remainder takes the difference; otherwise the bit is 0 and the remainder is restored.
  - Counter decrements; at 0, go to FIX. CALC lasts exactly widthX cycles.
- FIX:
  - Apply signs: Q = sQ ? -qmag : qmag; R = sD ? -rmag : rmag.
  - Ovf=1 if qmag > 2^(widthX-1)-1 and sQ=0, or qmag > 2^(widthX-1) and sQ=1. On Ovf, Q=0 and R=0.
  - Go to DONE.
- DONE:
  - OutValid=1; Q, R, DivZero and Ovf are held stable until OutReady.
  - On OutValid&OutReady, go to IDLE; flags and outputs clear to 0 on the same edge.
  - InReady=0 in all states except IDLE; no overlap of operations.
- Latency:
  - Normal: OutValid rises widthX+2 edges after the accepting edge.
  - DivZero or pre-check Ovf: 1 edge.
- Most-negative dividend: magnitude is computed in widthX+widthY+1 bits internally, so there is no wrap.
- InValid while busy is ignored; operands are sampled only at accept.

Optional Feature:
- Macro DIV_SGN_CS_IN_EN.
- Defined:
  - D is replaced by two ports DS and DC, each widthX+widthY bits, giving the dividend in carry-save form.
  - Dividend = DS+DC, summed at accept with the speed-selected adder and wrapped modulo 2^(widthX+widthY).
  - Adds one IDLE-to-CALC cycle (state LOAD), so normal latency is widthX+3.
- Undefined: single D port; latency as above.

Decomposition:
- Package div_sgn_pkg holds:
  - state enum typedef (IDLE, CALC, FIX, DONE, LOAD)
  - function latency(widthX, csIn)
  - constant for the magnitude width
- Sub-module div_sgn_step: combinational single restoring iteration.
  - Inputs: partial remainder, next dividend bit, |Y|.
  - Outputs: new partial remainder and quotient bit.

Test Plan (widthX=widthY=8):
- D=100, Y=7 -> Q=14, R=2, Ovf=0, DivZero=0; OutValid exactly 10 edges after accept.
- D=-100, Y=7 -> Q=-14, R=-2. D=100, Y=-7 -> Q=-14, R=2. D=-100, Y=-7 -> Q=14, R=-2.
- D=123, Y=0 -> DivZero=1, Q=0, R=0, OutValid 1 edge after accept.
- D=128, Y=1 -> Ovf=1 from FIX. D=-128, Y=1 -> Q=-128, Ovf=0. D=1000, Y=2 -> pre-check Ovf=1 after 1 edge.
- OutReady held 0 for 5 cycles -> Q/R/flags stable, InReady=0, a second InValid is ignored; release -> IDLE, next operation correct.
- RST_N pulsed low mid-CALC -> outputs 0 immediately, IDLE after release, following D=50, Y=5 -> Q=10, R=0.
